// File: rtl/csr_trap_ctrl_if.sv
// Pipeline <-> trap controller bundle: M-stage event inputs, CSR access port, and stall/flush/redirect controls.
// master = pipeline side, slave = csr_trap_ctrl.
interface csr_trap_ctrl_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] m_pc;
  logic            exc_valid;
  logic [3:0]      exc_code;
  logic [XLEN-1:0] exc_tval;
  logic            irq_ext;
  logic            mret_valid;
  logic            csr_wen;
  logic [11:0]     csr_idx;
  logic [XLEN-1:0] csr_wdat;
  logic [XLEN-1:0] csr_rdat;
  logic            stall;
  logic            flush;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output m_pc, exc_valid, exc_code, exc_tval, irq_ext, mret_valid,
           csr_wen, csr_idx, csr_wdat,
    input  csr_rdat, stall, flush, redirect_pc
  );

  modport slave (
    input  m_pc, exc_valid, exc_code, exc_tval, irq_ext, mret_valid,
           csr_wen, csr_idx, csr_wdat,
    output csr_rdat, stall, flush, redirect_pc
  );
endinterface

// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR file and trap/mret sequencer beside the M stage; traps and mret take two cycles
// (accept with stall, then flush+redirect). The pipeline is held by stall; the controller never waits on it.
module csr_trap_ctrl #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = 32'h00000080
) (
  input logic           clk,
  input logic           reset,
  csr_trap_ctrl_if.slave bus
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));
  localparam logic [XLEN-1:0] IRQ_CAUSE  = {1'b1, {(XLEN-5){1'b0}}, 4'hB};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRAP = 2'd1,
    MRET = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic            mstatus_mie;
  logic            mstatus_mpie;
  logic            mie_meie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mtval;

  logic irq_take;
  logic take_exc;
  logic take_irq;
  logic take_mret;
  logic do_csr_wr;

  assign irq_take = mstatus_mie & mie_meie & bus.irq_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Acceptance is strictly prioritised; a CSR write that loses to a trap/mret is dropped.
  always_comb begin
    next_state      = state;
    take_exc        = 1'b0;
    take_irq        = 1'b0;
    take_mret       = 1'b0;
    do_csr_wr       = 1'b0;
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
    bus.redirect_pc = '0;
    case (state)
      IDLE: begin
        if (bus.exc_valid) begin
          take_exc   = 1'b1;
          bus.stall  = 1'b1;
          next_state = TRAP;
        end else if (irq_take) begin
          take_irq   = 1'b1;
          bus.stall  = 1'b1;
          next_state = TRAP;
        end else if (bus.mret_valid) begin
          take_mret  = 1'b1;
          bus.stall  = 1'b1;
          next_state = MRET;
        end else if (bus.csr_wen) begin
          do_csr_wr  = 1'b1;
        end
      end
      TRAP: begin
        bus.stall       = 1'b1;
        bus.flush       = 1'b1;
        bus.redirect_pc = mtvec;
        next_state      = IDLE;
      end
      MRET: begin
        bus.stall       = 1'b1;
        bus.flush       = 1'b1;
        bus.redirect_pc = mepc;
        next_state      = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_meie     <= 1'b0;
      mtvec        <= MTVEC_RESET & ALIGN_MASK;
      mepc         <= '0;
      mcause       <= '0;
      mtval        <= '0;
    end else begin
      if (take_exc) begin
        mepc   <= bus.m_pc & ALIGN_MASK;
        mcause <= {{(XLEN-4){1'b0}}, bus.exc_code};
        mtval  <= bus.exc_tval;
      end else if (take_irq) begin
        mepc   <= bus.m_pc & ALIGN_MASK;
        mcause <= IRQ_CAUSE;
        mtval  <= '0;
      end

      // Interrupt-enable stack moves in the redirect cycle, so the IDLE cycle after a trap sees MIE=0.
      if (state == TRAP) begin
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (state == MRET) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end

      if (do_csr_wr) begin
        case (bus.csr_idx)
          ADDR_MSTATUS: begin
            mstatus_mie  <= bus.csr_wdat[3];
            mstatus_mpie <= bus.csr_wdat[7];
          end
          ADDR_MIE:    mie_meie <= bus.csr_wdat[11];
          ADDR_MTVEC:  mtvec    <= bus.csr_wdat & ALIGN_MASK;
          ADDR_MEPC:   mepc     <= bus.csr_wdat & ALIGN_MASK;
          ADDR_MCAUSE: mcause   <= bus.csr_wdat;
          ADDR_MTVAL:  mtval    <= bus.csr_wdat;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.csr_rdat = '0;
    case (bus.csr_idx)
      ADDR_MSTATUS: begin
        bus.csr_rdat[3] = mstatus_mie;
        bus.csr_rdat[7] = mstatus_mpie;
      end
      ADDR_MIE:    bus.csr_rdat[11] = mie_meie;
      ADDR_MTVEC:  bus.csr_rdat     = mtvec;
      ADDR_MEPC:   bus.csr_rdat     = mepc;
      ADDR_MCAUSE: bus.csr_rdat     = mcause;
      ADDR_MTVAL:  bus.csr_rdat     = mtval;
      ADDR_MIP:    bus.csr_rdat[11] = bus.irq_ext;
      default: ;
    endcase
  end

endmodule

// File: doc/csr_trap_ctrl.md
Name: csr_trap_ctrl

Overview:
Machine-mode trap sequencer and CSR file owner for the cpu6 core; sits beside the M stage of the datapath.
- Arbitrates three requesters of the CSR state: pipeline CSR instructions, synchronous exceptions, and the external interrupt plus mret.
- Sequences the mepc/mcause/mtval/mstatus updates for each trap or return.
- Drives the pipeline stall, flush and PC redirect.

Parameters:
XLEN, 32, data/address width (matches CPU6_XLEN)
MTVEC_RESET, 32'h00000080, mtvec reset value (direct mode)

Ports:
clk  in  1  core clock (cpu_clk)
reset  in  1  synchronous, active-high reset
m_pc  in  XLEN  PC of instruction in M stage
exc_valid  in  1  exception raised by M-stage instruction
exc_code  in  4  exception cause code
exc_tval  in  XLEN  trap value for exception
irq_ext  in  1  external interrupt, level
mret_valid  in  1  mret in M stage
csr_wen  in  1  CSR instruction write (csrrw/s/c result already computed)
csr_idx  in  12  CSR address for read and write
csr_wdat  in  XLEN  CSR write data
csr_rdat  out  XLEN  CSR read data, combinational from csr_idx
stall  out  1  hold IF..M
flush  out  1  squash IF..M, load redirect_pc
redirect_pc  out  XLEN  target PC, valid only with flush

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE; mstatus=0, mie=0, mepc=0, mcause=0, mtval=0; mtvec=MTVEC_RESET; stall=0, flush=0, redirect_pc=0.
- CSR address map:
  - mstatus 0x300: only MIE[3] and MPIE[7] are implemented; other bits read 0.
  - mie 0x304: only MEIE[11].
  - mtvec 0x305: bits[1:0] forced 0.
  - mepc 0x341: bits[1:0] forced 0.
  - mcause 0x342, mtval 0x343: full width.
  - mip 0x344: read-only; bit11 = irq_ext.
  - Unmapped index reads 0; writes to it are ignored.
- irq_take = mstatus.MIE & mie.MEIE & irq_ext.
- FSM states: IDLE, TRAP, MRET.
- IDLE accept priority (highest first): exc_valid > irq_take > mret_valid > csr_wen.
  - Only one event is accepted per cycle.
  - A csr_wen in the same cycle as an accepted trap or mret is dropped; its instruction is squashed.
- Exception accept (cycle t, IDLE):
  - stall=1 combinationally in t.
  - Edge end of t: mepc<=m_pc&~3, mcause<={0,exc_code}, mtval<=exc_tval; state->TRAP.
- Interrupt accept (cycle t, IDLE): same as exception, except mcause<=32'h8000000B and mtval<=0.
- TRAP state (t+1):
  - stall=1, flush=1, redirect_pc=mtvec.
  - Edge end of t+1: MPIE<=MIE, MIE<=0; state->IDLE.
  - Inputs are ignored in TRAP.
- mret accept (cycle t, IDLE): stall=1 in t; state->MRET.
- MRET state (t+1):
  - stall=1, flush=1, redirect_pc=mepc.
  - Edge end of t+1: MIE<=MPIE, MPIE<=1; state->IDLE.
- CSR write: accepted only in IDLE with no trap/mret accept; the addressed CSR updates at the end of that cycle. stall stays 0.
- Read/write timing: csr_rdat reflects the current registers; a write is visible the cycle after.
- Output defaults: flush=0 and redirect_pc=0 whenever state is IDLE.
- Masked interrupt: irq_ext high while masked has no effect except mip.
- Back-to-back events: irq_take cannot fire in the IDLE cycle after TRAP, because MIE is already 0.
- Reset mid-operation: reset in TRAP or MRET forces IDLE at that edge. The following cycle has flush=0, stall=0, and every register is at its reset value. Pending updates (including the MIE/MPIE update) are discarded.

Test Plan:
1. Reset for 2 cycles, then sweep csr_idx -> mtvec reads 0x00000080; mstatus, mie, mepc, mcause, mtval, mip read 0; stall=flush=0.
2. csr_wen, idx 0x341, wdat 0xffffffee -> next cycle csr_rdat=0xffffffec. Then wdat 0xffffffec & ~0x00000011 (csrrc) -> reads 0xffffffec.
3. Set mstatus=0x8; exc_valid code 2, m_pc 0x1c, tval 0xdeadbeef -> t: stall=1, flush=0; t+1: flush=1, redirect_pc=0x80, mepc=0x1c, mcause=2, mtval=0xdeadbeef; t+2: mstatus=0x80, stall=0.
4. From case 3, mret_valid -> t+1: flush=1, redirect_pc=0x1c; t+2: mstatus=0x88.
5. mie=0x800, mstatus=0x8, irq_ext=1, m_pc 0x30 -> mcause=0x8000000b, mepc=0x30, redirect 0x80, mtval=0. With mstatus=0 instead -> no stall or flush; mip reads 0x800.
6. Same cycle exc_valid + irq_take + csr_wen (idx 0x305, 0x100) -> exception taken (mcause=exc_code), mtvec stays 0x80. Then assert reset in TRAP cycle -> next cycle flush=0, mepc=0, state IDLE.
